// File: rtl/cacheline_adapter.sv
// Bridges a cache line request to a sequence of BEATS memory beats.
// Read bursts are assembled into line_o; write bursts stream the latched line out beat by beat.
module cacheline_adapter #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                          state;
  state_t                          state_n;
  logic [CNT_W-1:0]                cnt;
  logic [31:0]                     addr_q;
  logic [BEATS-1:0][BURST_W-1:0]   rline_q;
  logic [BEATS-1:0][BURST_W-1:0]   wline_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      rline_q <= '0;
      wline_q <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            addr_q <= address_i & ~32'h0000_001F;
            cnt    <= '0;
          end
          if (write_i) wline_q <= line_i;
        end
        READ: begin
          // Beats land in place, so line_o keeps the previous line until the first new beat.
          if (resp_i) begin
            rline_q[cnt] <= burst_i;
            cnt          <= cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          if (resp_i) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    case (state)
      IDLE: begin
        if (write_i)     state_n = WRITE;
        else if (read_i) state_n = READ;
      end
      READ: begin
        read_o = 1'b1;
        if (resp_i && cnt == LAST) state_n = DONE;
      end
      WRITE: begin
        write_o = 1'b1;
        if (resp_i && cnt == LAST) state_n = DONE;
      end
      DONE: begin
        resp_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign burst_o   = wline_q[cnt];
  assign address_o = addr_q;
  assign line_o    = rline_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: per-cycle vector table plus hand sequences
// for reset mid-burst and stray memory responses.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_adapter #(.LINE_W(256), .BURST_W(64)) dut (
    .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] BD = 64'hDDDD_DDDD_DDDD_DDDD;
  localparam logic [63:0] G1 = 64'h0101_0101_0101_0101;
  localparam logic [63:0] G2 = 64'h0202_0202_0202_0202;
  localparam logic [63:0] G3 = 64'h0303_0303_0303_0303;
  localparam logic [63:0] G4 = 64'h0404_0404_0404_0404;
  localparam logic [63:0] JK = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam logic [255:0] LW = {BD, BC, BB, BA};

  typedef struct {
    logic         rd, wr, rs;
    logic [31:0]  addr;
    logic [255:0] line;
    logic [63:0]  burst;
    logic         e_rd, e_wr, e_resp;
    logic         c_bo;
    logic [63:0]  e_bo;
    logic         c_addr;
    logic [31:0]  e_addr;
    logic         c_line;
    logic [255:0] e_line;
  } vec_t;

  vec_t         vecs[$];
  logic [31:0]  cur_addr, cur_eaddr;
  logic [255:0] cur_line, cur_eline;
  int           n_chk = 0;
  int           n_fail = 0;

  function automatic void add(logic rd, logic wr, logic rs, logic [63:0] b,
                              logic er, logic ew, logic eresp,
                              logic cbo, logic [63:0] ebo, logic ca, logic cl);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rs = rs; v.addr = cur_addr; v.line = cur_line; v.burst = b;
    v.e_rd = er; v.e_wr = ew; v.e_resp = eresp;
    v.c_bo = cbo; v.e_bo = ebo; v.c_addr = ca; v.e_addr = cur_eaddr;
    v.c_line = cl; v.e_line = cur_eline;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rs, input logic [63:0] b);
    read_i = rd; write_i = wr; resp_i = rs; burst_i = b;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ea,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3, input string tag);
    logic [63:0] bs[4];
    bs = '{b0, b1, b2, b3};
    address_i = a;
    drive(1'b1, 1'b0, 1'b0, '0);
    chk({tag, " idle resp_o"}, resp_o, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 1'b1, bs[k]);
      chk({tag, " beat read_o"}, read_o, 1);
      chk({tag, " beat address_o"}, address_o, ea);
      chk({tag, " beat resp_o"}, resp_o, 0);
      step();
    end
    drive(1'b1, 1'b0, 1'b0, '0);
    chk({tag, " done resp_o"}, resp_o, 1);
    chk({tag, " done line_o"}, line_o, {b3, b2, b1, b0});
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk({tag, " after resp_o"}, resp_o, 0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 0; write_i = 0; resp_i = 0; burst_i = '0;
    step();
    step();
    @(negedge clk);
    chk("rst resp_o", resp_o, 0);
    chk("rst read_o", read_o, 0);
    chk("rst write_o", write_o, 0);
    chk("rst address_o", address_o, 0);
    chk("rst burst_o", burst_o, 0);
    chk("rst line_o", line_o, 0);
    step();
    rst = 1'b0;

    // Back-to-back read: resp_o at cycle 5
    cur_addr = 32'h0000_1234; cur_eaddr = 32'h0000_1220; cur_line = '0; cur_eline = '0;
    add(1, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
    add(1, 0, 1, B1, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 1, B2, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 1, B3, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 1, B4, 1, 0, 0, 0, '0, 1, 0);
    cur_eline = {B4, B3, B2, B1};
    add(1, 0, 0, '0, 0, 0, 1, 0, '0, 0, 1);
    add(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 1);

    // Back-to-back write; line_o keeps the last read line
    cur_addr = 32'h0000_ABCF; cur_eaddr = 32'h0000_ABC0; cur_line = LW;
    add(0, 1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
    add(0, 1, 1, '0, 0, 1, 0, 1, BA, 1, 1);
    add(0, 1, 1, '0, 0, 1, 0, 1, BB, 1, 1);
    add(0, 1, 1, '0, 0, 1, 0, 1, BC, 1, 1);
    add(0, 1, 1, '0, 0, 1, 0, 1, BD, 1, 1);
    add(0, 1, 0, '0, 0, 0, 1, 0, '0, 0, 1);
    add(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0);

    // Both requests high -> write wins; gaps; inputs change after the latch
    cur_addr = 32'hFFFF_FFFF; cur_eaddr = 32'hFFFF_FFE0; cur_line = ~LW;
    add(1, 1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
    cur_addr = 32'h0; cur_line = '0;
    add(1, 1, 0, JK, 0, 1, 0, 1, ~BA, 1, 0);
    add(1, 1, 1, JK, 0, 1, 0, 1, ~BA, 1, 0);
    add(1, 1, 1, JK, 0, 1, 0, 1, ~BB, 1, 0);
    add(1, 1, 0, JK, 0, 1, 0, 1, ~BC, 1, 0);
    add(1, 1, 1, JK, 0, 1, 0, 1, ~BC, 1, 0);
    add(1, 1, 1, JK, 0, 1, 0, 1, ~BD, 1, 0);
    add(1, 1, 0, '0, 0, 0, 1, 0, '0, 0, 1);
    // Write still held after resp_o starts a new transaction
    cur_addr = 32'h0000_0047; cur_eaddr = 32'h0000_0040; cur_line = LW;
    add(0, 1, 0, '0, 0, 0, 0, 0, '0, 0, 0);
    add(0, 1, 1, '0, 0, 1, 0, 1, BA, 1, 0);
    add(0, 1, 1, '0, 0, 1, 0, 1, BB, 1, 0);
    add(0, 1, 1, '0, 0, 1, 0, 1, BC, 1, 0);
    add(0, 1, 1, '0, 0, 1, 0, 1, BD, 1, 0);
    add(0, 1, 0, '0, 0, 0, 1, 0, '0, 0, 1);
    add(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 1);

    // Read with gaps: beats at cycles 1,3,4,7 -> resp_o at cycle 8
    cur_addr = 32'h8000_003F; cur_eaddr = 32'h8000_0020; cur_line = '0;
    add(1, 0, 0, '0, 0, 0, 0, 0, '0, 0, 0);
    add(1, 0, 1, G1, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 0, JK, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 1, G2, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 1, G3, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 0, JK, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 0, JK, 1, 0, 0, 0, '0, 1, 0);
    add(1, 0, 1, G4, 1, 0, 0, 0, '0, 1, 0);
    cur_eline = {G4, G3, G2, G1};
    add(1, 0, 0, '0, 0, 0, 1, 0, '0, 0, 1);
    add(0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 1);

    foreach (vecs[i]) begin
      address_i = vecs[i].addr;
      line_i    = vecs[i].line;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].rs, vecs[i].burst);
      chk($sformatf("row%0d read_o", i), read_o, vecs[i].e_rd);
      chk($sformatf("row%0d write_o", i), write_o, vecs[i].e_wr);
      chk($sformatf("row%0d resp_o", i), resp_o, vecs[i].e_resp);
      if (vecs[i].c_bo)   chk($sformatf("row%0d burst_o", i), burst_o, vecs[i].e_bo);
      if (vecs[i].c_addr) chk($sformatf("row%0d address_o", i), address_o, vecs[i].e_addr);
      if (vecs[i].c_line) chk($sformatf("row%0d line_o", i), line_o, vecs[i].e_line);
      step();
    end

    // Reset after the second read beat abandons the burst
    address_i = 32'h0000_2000;
    drive(1'b1, 1'b0, 1'b0, '0);
    step();
    drive(1'b1, 1'b0, 1'b1, 64'hE1E1_E1E1_E1E1_E1E1);
    chk("rstmid beat1 read_o", read_o, 1);
    step();
    drive(1'b1, 1'b0, 1'b1, 64'hE2E2_E2E2_E2E2_E2E2);
    step();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 64'hE3E3_E3E3_E3E3_E3E3);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("rstmid read_o", read_o, 0);
    chk("rstmid write_o", write_o, 0);
    chk("rstmid resp_o", resp_o, 0);
    chk("rstmid line_o", line_o, 0);
    chk("rstmid address_o", address_o, 0);
    chk("rstmid burst_o", burst_o, 0);
    step();
    drive(1'b0, 1'b0, 1'b0, '0);
    chk("rstmid later resp_o", resp_o, 0);
    step();
    do_read(32'h0000_3000, 32'h0000_3000, 64'h5555_0000_0000_0005, 64'h6666_0000_0000_0006,
            64'h7777_0000_0000_0007, 64'h8888_0000_0000_0008, "fresh");

    // Stray resp_i in IDLE is ignored
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("stray resp_o", resp_o, 0);
      chk("stray read_o", read_o, 0);
      chk("stray line_o", line_o, {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007,
                                   64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005});
      step();
    end
    do_read(32'h0000_005C, 32'h0000_0040, 64'h0A0A_0A0A_1234_0001, 64'h0B0B_0B0B_1234_0002,
            64'h0C0C_0C0C_1234_0003, 64'h0D0D_0D0D_1234_0004, "stray");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_adapter.md
CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

Interface
REQ-001 The module SHALL have parameter LINE_W, default 256, giving the cache line width in bits.
REQ-002 The module SHALL have parameter BURST_W, default 64, giving the memory beat width in bits; BEATS = LINE_W/BURST_W = 4.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  is the reset, synchronous and active-high.
REQ-005 Port line_i  input  LINE_W  is the write line from the cache (pmem_wdata side).
REQ-006 Port line_o  output  LINE_W  is the assembled read line to the cache (pmem_rdata side).
REQ-007 Port address_i  input  32  is the cache line address from the cache.
REQ-008 Port read_i  input  1  is the cache line-read request, held until resp_o.
REQ-009 Port write_i  input  1  is the cache line-write request, held until resp_o.
REQ-010 Port resp_o  output  1  is the one-cycle completion pulse to the cache.
REQ-011 Port burst_i  input  BURST_W  is the read beat from memory.
REQ-012 Port burst_o  output  BURST_W  is the write beat to memory.
REQ-013 Port address_o  output  32  is the line-aligned memory address.
REQ-014 Port read_o  output  1  is the memory burst-read request.
REQ-015 Port write_o  output  1  is the memory burst-write request.
REQ-016 Port resp_i  input  1  marks one beat transferred in that cycle.

Function
REQ-017 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-018 IDLE: write_i high -> WRITE; else read_i high -> READ; else stay; write_i has priority when both are high.
REQ-019 On leaving IDLE, the block SHALL latch address_i with bits [4:0] forced to 0, latch line_i (write), and clear beat counter cnt (2 bits).
REQ-020 READ: read_o=1; on each resp_i cycle, burst_i SHALL be stored into line bits [BURST_W*cnt +: BURST_W] and cnt increments; after the beat with cnt=3, go to DONE.
REQ-021 WRITE: write_o=1; burst_o SHALL equal latched line bits [BURST_W*cnt +: BURST_W] combinationally; each resp_i cycle advances cnt; after the beat with cnt=3, go to DONE.
REQ-022 Cycles in READ/WRITE with resp_i low SHALL hold cnt and data; beats need not be consecutive.
REQ-023 DONE: resp_o=1 for exactly one cycle; read_o=write_o=0; next state IDLE.
REQ-024 resp_i in IDLE or DONE SHALL be ignored.
REQ-025 address_o SHALL equal the latched aligned address throughout READ/WRITE and be constant for the whole burst.
REQ-026 line_o SHALL hold the last fully assembled line from DONE until the next read's first beat; partially assembled lines SHALL not be visible as a completed response.
REQ-027 read_o and write_o SHALL never be high simultaneously.
REQ-028 Minimum latency: request in IDLE at cycle 0, four back-to-back resp_i at cycles 1-4, resp_o at cycle 5.
REQ-029 A request still held in the cycle after resp_o SHALL start a new transaction (cache drops it on resp_o).

Reset
REQ-030 With rst high at a clock edge, state -> IDLE, cnt -> 0, line_o -> 0, latched address -> 0, latched write line -> 0.
REQ-031 During and after reset: resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0.
REQ-032 Reset mid-burst SHALL abandon the burst: no resp_o, request lines drop next cycle, partial data discarded.

Verification
REQ-033 Read, address_i=0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 back-to-back -> address_o=0x0000_1220, line_o={0x44..44,0x33..33,0x22..22,0x11..11}, resp_o at cycle 5.
REQ-034 Write, line_i=0xDDDD..CCCC..BBBB..AAAA (64-bit quarters, low first AAAA) -> burst_o sequence AAAA,BBBB,CCCC,DDDD, write_o high 4 cycles, one resp_o.
REQ-035 Read with resp_i gaps (beats at cycles 1,3,4,7) -> correct line, resp_o at cycle 8, cnt holds in gap cycles.
REQ-036 read_i and write_i both high in IDLE -> WRITE burst only, read_o stays 0.
REQ-037 rst asserted after second read beat -> read_o=0 next cycle, no resp_o, following read completes with fresh data only.
REQ-038 Stray resp_i in IDLE, then normal read -> no early resp_o, line assembled from the four in-burst beats only.
